// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// FSM state encoding, mux select constants and a grant decode helper.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Mux select values: 0 routes in1, 1 routes in2.
    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

    // One-hot grant vector for a given state: {owner1, owner0}, 00 when idle.
    function automatic logic [1:0] grant_of(input arb_state_e st);
        logic [1:0] g;
        g = 2'b00;
        case (st)
            ST_OWN0: g = 2'b01;
            ST_OWN1: g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mux_out_reg.sv
// Valid/ready output register for the muxed data. A load captures the
// presented word; an accept without a load empties the stage; a stalled
// stage (valid and not ready) holds its word.
module mux_out_reg #(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dout,
    output logic              out_valid,
    output logic              accept
);

    logic [DATA_W-1:0] data_r;
    logic              valid_r;

    // The stage can take a new word when empty or when the consumer drains it now.
    always_comb begin
        accept = ~valid_r | out_ready;
    end

    // Capture on load, drop valid on drain without refill, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= din;
            valid_r <= 1'b1;
        end else if (accept) begin
            valid_r <= 1'b0;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
        end
    end

    assign dout      = data_r;
    assign out_valid = valid_r;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter in front of a 2:1 data mux. The FSM owns the mux
// select, limits each grant to MAX_BURST beats and feeds the selected
// input into a registered valid/ready output stage.
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 2,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [1:0]        gnt,
    output logic              addr,
    output logic [DATA_W-1:0] Mout,
    output logic              mout_valid,
    input  logic              mout_ready,
    output logic              busy
);

    // Count value at which the next beat completes the burst.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic              last_r;
    logic              last_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [1:0]        gnt_r;
    logic [1:0]        gnt_nxt_s;
    logic              addr_r;
    logic              addr_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;

    logic              owner_s;
    logic              owning_s;
    logic              req_own_s;
    logic              req_oth_s;
    logic              accept_s;
    logic              beat_s;
    logic              release_s;
    logic [DATA_W-1:0] mux_data_s;

    // Decode current owner, its request and the beat / release conditions.
    always_comb begin
        owner_s    = (state_r == ST_OWN1);
        owning_s   = (state_r != ST_IDLE);
        req_own_s  = owner_s ? req[1] : req[0];
        req_oth_s  = owner_s ? req[0] : req[1];
        beat_s     = owning_s & req_own_s & accept_s;
        release_s  = owning_s & (~req_own_s | (beat_s & (cnt_r == BURST_LAST)));
        mux_data_s = (addr_r == SEL_IN2) ? in2 : in1;
    end

    // Next-state logic: round-robin pick from IDLE, burst/drop release while owning.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                case (req)
                    2'b01:   state_nxt_s = ST_OWN0;
                    2'b10:   state_nxt_s = ST_OWN1;
                    2'b11:   state_nxt_s = last_r ? ST_OWN0 : ST_OWN1;
                    default: state_nxt_s = ST_IDLE;
                endcase
            end
            ST_OWN0, ST_OWN1: begin
                if (release_s) begin
                    last_nxt_s = owner_s;
                    cnt_nxt_s  = {CNT_W{1'b0}};
                    if (req_oth_s) begin
                        state_nxt_s = owner_s ? ST_OWN0 : ST_OWN1;
                    end else if (req_own_s) begin
                        state_nxt_s = state_r;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (beat_s) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so grant, select and busy are registered with it.
    always_comb begin
        gnt_nxt_s  = grant_of(state_nxt_s);
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        case (state_nxt_s)
            ST_OWN0: addr_nxt_s = SEL_IN1;
            ST_OWN1: addr_nxt_s = SEL_IN2;
            default: addr_nxt_s = addr_r;
        endcase
    end

    // State, round-robin pointer, burst counter and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            last_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            gnt_r   <= 2'b00;
            addr_r  <= SEL_IN1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
            cnt_r   <= cnt_nxt_s;
            gnt_r   <= gnt_nxt_s;
            addr_r  <= addr_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    mux_out_reg #(
        .DATA_W(DATA_W)
    ) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (beat_s),
        .din      (mux_data_s),
        .out_ready(mout_ready),
        .dout     (Mout),
        .out_valid(mout_valid),
        .accept   (accept_s)
    );

    assign gnt  = gnt_r;
    assign addr = addr_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios followed by random traffic,
// driving a MAX_BURST=4 and a MAX_BURST=1 instance from the same inputs and
// checking both against a behavioural owner/burst/output-slot model.
module tb_mux2_rr_arbiter;

    typedef struct {
        int         owner;   // -1 idle, else requester index
        int         last;
        int         beats;
        logic       addr;
        logic       mv;
        logic [1:0] md;
    } model_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] in1;
    logic [1:0] in2;
    logic       mout_ready;

    logic [1:0] gnt4, gnt1;
    logic       addr4, addr1;
    logic [1:0] mout4, mout1;
    logic       mv4, mv1;
    logic       busy4, busy1;

    int total;
    int bad;

    model_t m4;
    model_t m1;

    mux2_rr_arbiter #(.DATA_W(2), .MAX_BURST(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .in1(in1), .in2(in2),
        .gnt(gnt4), .addr(addr4), .Mout(mout4), .mout_valid(mv4),
        .mout_ready(mout_ready), .busy(busy4)
    );

    mux2_rr_arbiter #(.DATA_W(2), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .in1(in1), .in2(in2),
        .gnt(gnt1), .addr(addr1), .Mout(mout1), .mout_valid(mv1),
        .mout_ready(mout_ready), .busy(busy1)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.owner = -1;
        m.last  = 1;
        m.beats = 0;
        m.addr  = 1'b0;
        m.mv    = 1'b0;
        m.md    = 2'b00;
        return m;
    endfunction

    // One clock of the arbiter as described behaviourally: who owns, whether
    // a word moves into the output slot, when the grant is given up.
    function automatic model_t model_step(input model_t m, input int max_burst,
                                          input logic [1:0] rq, input logic [1:0] a,
                                          input logic [1:0] b, input logic rdy);
        model_t n;
        bit     room;
        bit     moved;
        int     x;
        n     = m;
        room  = !m.mv || rdy;
        moved = 0;
        if (m.owner >= 0) begin
            x = m.owner;
            if (rq[x] && room) begin
                moved = 1;
                n.md  = (x == 1) ? b : a;
                n.mv  = 1'b1;
                n.beats = m.beats + 1;
            end else if (room) begin
                n.mv = 1'b0;
            end
            if (!rq[x] || (moved && n.beats == max_burst)) begin
                n.last  = x;
                n.beats = 0;
                if (rq[1-x])      n.owner = 1 - x;
                else if (rq[x])   n.owner = x;
                else              n.owner = -1;
            end
        end else begin
            if (room) n.mv = 1'b0;
            if (rq == 2'b11)      n.owner = 1 - m.last;
            else if (rq == 2'b01) n.owner = 0;
            else if (rq == 2'b10) n.owner = 1;
            else                  n.owner = -1;
        end
        if (n.owner >= 0) n.addr = (n.owner == 1);
        return n;
    endfunction

    task automatic check_inst(input string pfx, input model_t m, input logic [1:0] g,
                              input logic a, input logic [1:0] mo, input logic v,
                              input logic bz);
        logic [1:0] eg;
        eg = (m.owner == 0) ? 2'b01 : (m.owner == 1) ? 2'b10 : 2'b00;
        chk({pfx, "_gnt"},  {30'd0, g},  {30'd0, eg});
        chk({pfx, "_addr"}, {31'd0, a},  {31'd0, m.addr});
        chk({pfx, "_mv"},   {31'd0, v},  {31'd0, m.mv});
        chk({pfx, "_busy"}, {31'd0, bz}, {31'd0, (m.owner >= 0)});
        if (m.mv) chk({pfx, "_mout"}, {30'd0, mo}, {30'd0, m.md});
        else if (m.owner < 0 && m.beats == 0 && !m.mv && m.md == 2'b00)
            chk({pfx, "_mout0"}, {30'd0, mo}, {30'd0, m.md});
    endtask

    task automatic check_all();
        check_inst("b4", m4, gnt4, addr4, mout4, mv4, busy4);
        check_inst("b1", m1, gnt1, addr1, mout1, mv1, busy1);
    endtask

    // Apply inputs at a falling edge, advance models, check at the next falling edge.
    task automatic cyc(input logic [1:0] rq, input logic [1:0] a, input logic [1:0] b,
                       input logic rdy);
        req        = rq;
        in1        = a;
        in2        = b;
        mout_ready = rdy;
        m4 = model_step(m4, 4, rq, a, b, rdy);
        m1 = model_step(m1, 1, rq, a, b, rdy);
        @(negedge clk);
        check_all();
    endtask

    task automatic rnd_cyc(input int req_bias, input int rdy_bias);
        logic [1:0] rq;
        rq[0] = ($urandom_range(0, 99) < req_bias);
        rq[1] = ($urandom_range(0, 99) < req_bias);
        cyc(rq, 2'($urandom), 2'($urandom), ($urandom_range(0, 99) < rdy_bias));
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        m4 = model_reset();
        m1 = model_reset();
        check_all();
        chk("rst_mout4", {30'd0, mout4}, 32'd0);
        chk("rst_mout1", {30'd0, mout1}, 32'd0);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        req        = 2'b00;
        in1        = 2'b00;
        in2        = 2'b00;
        mout_ready = 1'b0;
        m4 = model_reset();
        m1 = model_reset();
        @(negedge clk);
        check_all();
        chk("reset_mout", {30'd0, mout4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester 0: grant after one cycle, data the cycle after, burst renews.
        for (int i = 0; i < 10; i++) cyc(2'b01, 2'b01, 2'b11, 1'b1);
        for (int i = 0; i < 2; i++)  cyc(2'b00, 2'b00, 2'b00, 1'b1);

        // Both requesting: alternating bursts with no gaps.
        for (int i = 0; i < 14; i++) cyc(2'b11, 2'b01, 2'b10, 1'b1);

        // Stall for three cycles mid-burst, then resume.
        for (int i = 0; i < 3; i++)  cyc(2'b11, 2'b01, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++)  cyc(2'b11, 2'b01, 2'b10, 1'b1);
        for (int i = 0; i < 2; i++)  cyc(2'b00, 2'b00, 2'b00, 1'b1);

        // Requester 0 drops after two beats; later tie goes to requester 1.
        for (int i = 0; i < 3; i++)  cyc(2'b01, 2'b10, 2'b01, 1'b1);
        for (int i = 0; i < 2; i++)  cyc(2'b00, 2'b10, 2'b01, 1'b1);
        for (int i = 0; i < 3; i++)  cyc(2'b11, 2'b10, 2'b01, 1'b1);

        // Drop while stalled: grant released, held beat stays valid.
        cyc(2'b10, 2'b00, 2'b11, 1'b0);
        cyc(2'b00, 2'b00, 2'b11, 1'b0);
        cyc(2'b00, 2'b00, 2'b11, 1'b1);

        // Reset during an OWN1 burst with a pending beat, then tie goes to requester 0.
        for (int i = 0; i < 3; i++)  cyc(2'b10, 2'b01, 2'b10, 1'b0);
        pulse_reset();
        for (int i = 0; i < 6; i++)  cyc(2'b11, 2'b01, 2'b10, 1'b1);

        // Random traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) pulse_reset();
            else rnd_cyc(75, 70);
        end
        for (int i = 0; i < 1000; i++) rnd_cyc(40, 90);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
